// File: rtl/cpu_pkg.sv
// Shared decode constants for the fetch/decode pipeline.
//   - Opcode and R-type funct encodings for the supported instruction set.
//   - ALU operation and fetch-redirect (BranchCtr) encodings.
//   - ID/EX control bundle type and the canonical NOP word.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] NOP_INSTR = 32'd0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE   = 3'd0,
    BR_BRANCH = 3'd1,
    BR_JUMP   = 3'd2
  } br_ctr_e;

  typedef struct packed {
    logic    valid;
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
  } de_ctrl_t;

endpackage

// File: rtl/instruction_decode_if.sv
// Bundle of all non-clock signals around the decode stage.
//   master : environment side (fetch + writeback drive PC/IR/WB_*, consume outputs)
//   slave  : decode stage side
// Signals: PC, IR, WB_RegWrite, WB_Rd, WB_Data (to decode);
//          BranchCtr, BranchAddr (to fetch); DE_* and Illegal (to execute).
interface instruction_decode_if #(
  parameter int DATA_W   = 32,
  parameter int RF_DEPTH = 32
);
  localparam int IDX_W = $clog2(RF_DEPTH);

  logic [DATA_W-1:0] PC;
  logic [DATA_W-1:0] IR;
  logic              WB_RegWrite;
  logic [IDX_W-1:0]  WB_Rd;
  logic [DATA_W-1:0] WB_Data;

  logic [2:0]        BranchCtr;
  logic [DATA_W-1:0] BranchAddr;

  logic [DATA_W-1:0] DE_PC;
  logic [DATA_W-1:0] DE_RsData;
  logic [DATA_W-1:0] DE_RtData;
  logic [DATA_W-1:0] DE_Imm;
  logic [IDX_W-1:0]  DE_Rd;
  logic [2:0]        DE_ALUOp;
  logic              DE_ALUSrc;
  logic              DE_RegWrite;
  logic              DE_MemRead;
  logic              DE_MemWrite;
  logic              DE_Valid;
  logic              Illegal;

  modport master (
    output PC, IR, WB_RegWrite, WB_Rd, WB_Data,
    input  BranchCtr, BranchAddr,
    input  DE_PC, DE_RsData, DE_RtData, DE_Imm, DE_Rd, DE_ALUOp, DE_ALUSrc,
    input  DE_RegWrite, DE_MemRead, DE_MemWrite, DE_Valid, Illegal
  );

  modport slave (
    input  PC, IR, WB_RegWrite, WB_Rd, WB_Data,
    output BranchCtr, BranchAddr,
    output DE_PC, DE_RsData, DE_RtData, DE_Imm, DE_Rd, DE_ALUOp, DE_ALUSrc,
    output DE_RegWrite, DE_MemRead, DE_MemWrite, DE_Valid, Illegal
  );
endinterface

// File: rtl/instruction_decode_regfile.sv
// register_file: 2-read / 1-write architectural register file.
//   clk, rst_n        : clock, async active-low reset (clears every register)
//   i_rs_idx/i_rt_idx : asynchronous read indices
//   o_rs_data/o_rt_data : read data, with same-cycle writeback bypass
//   i_wr_en/i_wr_idx/i_wr_data : write port, committed on rising clk
// Register 0 is hardwired to zero: writes are dropped and reads return 0.
module register_file #(
  parameter int DATA_W   = 32,
  parameter int RF_DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(RF_DEPTH)-1:0] i_rs_idx,
  input  logic [$clog2(RF_DEPTH)-1:0] i_rt_idx,
  input  logic                       i_wr_en,
  input  logic [$clog2(RF_DEPTH)-1:0] i_wr_idx,
  input  logic [DATA_W-1:0]          i_wr_data,
  output logic [DATA_W-1:0]          o_rs_data,
  output logic [DATA_W-1:0]          o_rt_data
);
  localparam int IDX_W = $clog2(RF_DEPTH);

  logic [DATA_W-1:0] r_regs [RF_DEPTH];
  logic              w_wr_live;

  assign w_wr_live = i_wr_en && (i_wr_idx != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_regs[i_wr_idx] <= i_wr_data;
    end
  end

  // Bypass lets decode see a value being written back in the same cycle.
  function automatic logic [DATA_W-1:0] read_port(input logic [IDX_W-1:0] idx);
    if (idx == '0)
      return '0;
    else if (w_wr_live && (idx == i_wr_idx))
      return i_wr_data;
    else
      return r_regs[idx];
  endfunction

  always_comb begin
    o_rs_data = read_port(i_rs_idx);
    o_rt_data = read_port(i_rt_idx);
  end

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: second pipeline stage, downstream of fetch.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of instruction_decode_if
//                in : PC (IR address + 4), IR, WB_RegWrite/WB_Rd/WB_Data
//                out: BranchCtr/BranchAddr redirect to fetch (registered),
//                     DE_* ID/EX pipeline register, sticky Illegal flag
// beq/bne/j are resolved here; the sequential instruction fetched behind a
// taken redirect is squashed to a bubble for one cycle.
module instruction_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RF_DEPTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_decode_if.slave bus
);
  localparam int IDX_W = $clog2(RF_DEPTH);

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [IDX_W-1:0]  w_rs_idx;
  logic [IDX_W-1:0]  w_rt_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [DATA_W-1:0] w_br_target;
  logic [DATA_W-1:0] w_j_target;
  logic              w_unused_shamt;

  de_ctrl_t          w_ctl;
  logic [IDX_W-1:0]  w_de_rd;
  br_ctr_e           w_br_ctr;
  logic [DATA_W-1:0] w_br_addr;
  logic              w_illegal;

  de_ctrl_t          r_ctl;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rs;
  logic [DATA_W-1:0] r_rt;
  logic [DATA_W-1:0] r_imm;
  logic [IDX_W-1:0]  r_rd;
  br_ctr_e           r_br_ctr;
  logic [DATA_W-1:0] r_br_addr;
  logic              r_squash;
  logic              r_illegal;

  assign w_op           = bus.IR[31:26];
  assign w_funct        = bus.IR[5:0];
  assign w_rs_idx       = bus.IR[21 +: IDX_W];
  assign w_rt_idx       = bus.IR[16 +: IDX_W];
  assign w_rd_idx       = bus.IR[11 +: IDX_W];
  assign w_unused_shamt = ^bus.IR[10:6];

  assign w_imm       = {{(DATA_W-16){bus.IR[15]}}, bus.IR[15:0]};
  assign w_br_target = bus.PC + (w_imm << 2);
  assign w_j_target  = {bus.PC[DATA_W-1 -: 4], bus.IR[25:0], 2'b00};

  register_file #(
    .DATA_W   (DATA_W),
    .RF_DEPTH (RF_DEPTH)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rs_idx  (w_rs_idx),
    .i_rt_idx  (w_rt_idx),
    .i_wr_en   (bus.WB_RegWrite),
    .i_wr_idx  (bus.WB_Rd),
    .i_wr_data (bus.WB_Data),
    .o_rs_data (w_rs_data),
    .o_rt_data (w_rt_data)
  );

  // Branches and jumps travel down as valid slots with every execute
  // control cleared; only the redirect carries their effect.
  always_comb begin
    w_ctl     = '0;
    w_de_rd   = '0;
    w_br_ctr  = BR_NONE;
    w_br_addr = w_br_target;
    w_illegal = 1'b0;
    if (!r_squash && (bus.IR != NOP_INSTR)) begin
      case (w_op)
        OP_RTYPE: begin
          w_ctl.valid     = 1'b1;
          w_ctl.reg_write = 1'b1;
          w_de_rd         = w_rd_idx;
          case (w_funct)
            FN_ADD:  w_ctl.alu_op = ALU_ADD;
            FN_SUB:  w_ctl.alu_op = ALU_SUB;
            FN_AND:  w_ctl.alu_op = ALU_AND;
            FN_OR:   w_ctl.alu_op = ALU_OR;
            FN_SLT:  w_ctl.alu_op = ALU_SLT;
            default: begin
              w_ctl     = '0;
              w_de_rd   = '0;
              w_illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI: begin
          w_ctl.valid     = 1'b1;
          w_ctl.alu_src   = 1'b1;
          w_ctl.reg_write = 1'b1;
          w_de_rd         = w_rt_idx;
        end
        OP_LW: begin
          w_ctl.valid     = 1'b1;
          w_ctl.alu_src   = 1'b1;
          w_ctl.reg_write = 1'b1;
          w_ctl.mem_read  = 1'b1;
          w_de_rd         = w_rt_idx;
        end
        OP_SW: begin
          w_ctl.valid     = 1'b1;
          w_ctl.alu_src   = 1'b1;
          w_ctl.mem_write = 1'b1;
        end
        OP_BEQ: begin
          w_ctl.valid = 1'b1;
          if (w_rs_data == w_rt_data) w_br_ctr = BR_BRANCH;
        end
        OP_BNE: begin
          w_ctl.valid = 1'b1;
          if (w_rs_data != w_rt_data) w_br_ctr = BR_BRANCH;
        end
        OP_J: begin
          w_ctl.valid = 1'b1;
          w_br_ctr    = BR_JUMP;
          w_br_addr   = w_j_target;
        end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  // squash follows BranchCtr by construction: it is set on the edge that
  // registers a redirect, and the squashed slot can never redirect, so it
  // self-clears on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl     <= '0;
      r_pc      <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_br_ctr  <= BR_NONE;
      r_br_addr <= '0;
      r_squash  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_ctl     <= w_ctl;
      r_pc      <= bus.PC;
      r_rs      <= w_rs_data;
      r_rt      <= w_rt_data;
      r_imm     <= w_imm;
      r_rd      <= w_de_rd;
      r_br_ctr  <= w_br_ctr;
      if (w_br_ctr != BR_NONE) r_br_addr <= w_br_addr;
      r_squash  <= (w_br_ctr != BR_NONE);
      r_illegal <= r_illegal | w_illegal;
    end
  end

  assign bus.BranchCtr   = r_br_ctr;
  assign bus.BranchAddr  = r_br_addr;
  assign bus.DE_PC       = r_pc;
  assign bus.DE_RsData   = r_rs;
  assign bus.DE_RtData   = r_rt;
  assign bus.DE_Imm      = r_imm;
  assign bus.DE_Rd       = r_rd;
  assign bus.DE_ALUOp    = r_ctl.alu_op;
  assign bus.DE_ALUSrc   = r_ctl.alu_src;
  assign bus.DE_RegWrite = r_ctl.reg_write;
  assign bus.DE_MemRead  = r_ctl.mem_read;
  assign bus.DE_MemWrite = r_ctl.mem_write;
  assign bus.DE_Valid    = r_ctl.valid;
  assign bus.Illegal     = r_illegal;

endmodule
